dmac_ahb_burst_master: RTL and testbench

//  AHB-Lite master engine of the DMAC channel. Consumes the programmed channel registers (source/dest

---
 rtl/dmac_ahb_burst_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_dmac_ahb_burst_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_ahb_burst_master.sv
// AHB-Lite burst master of a DMAC channel: reads one burst from the source into a word buffer,
// then writes it to the destination, and repeats until the programmed transfer size is used up.
module dmac_ahb_burst_master #(
    parameter int BUF_DEPTH = 16,
    parameter int TS_W      = 12
) (
    input  logic            r_HCLK,
    input  logic            r_HRESETn,
    input  logic            start,
    input  logic [31:0]     src_addr,
    input  logic [31:0]     dest_addr,
    input  logic [TS_W-1:0] ts,
    input  logic [2:0]      bs,
    input  logic            m_HGRANT,
    input  logic            m_HREADY,
    input  logic [1:0]      m_HRESP,
    input  logic [31:0]     m_HRDATA,
    output logic            m_HBUSREQ,
    output logic [31:0]     m_HADDR,
    output logic [1:0]      m_HTRANS,
    output logic            m_HWRITE,
    output logic [2:0]      m_HSIZE,
    output logic [2:0]      m_HBURST,
    output logic [31:0]     m_HWDATA,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int WC_W = TS_W - 2;
    localparam int BI_W = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_RD_LAST,
        S_WR,
        S_WR_LAST,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [WC_W-1:0]  words_q;
    logic [2:0]       bs_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             gap_q;
    logic [4:0]       beat_p0;
    logic             vld_p1;
    logic [BI_W-1:0]  beat_p1;
    logic [31:0]      buf_q [BUF_DEPTH];

    logic [4:0]       blen;
    logic [4:0]       nbeats;
    logic             last_beat;
    logic             bus_err;
    logic             accept;
    logic             beat_go;
    logic [2:0]       hburst_cur;
    logic             unused_bits;

    function automatic logic [4:0] burst_len(input logic [2:0] code);
        case (code)
            3'd1:    return 5'd4;
            3'd2:    return 5'd8;
            3'd3:    return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

    // A burst that matches the programmed length gets its fixed INCRx code; a short tail uses INCR.
    function automatic logic [2:0] burst_code(input logic [2:0] code, input logic [4:0] n,
                                              input logic [4:0] len);
        if (n == 5'd1) begin
            return 3'b000;
        end else if (n == len) begin
            case (code)
                3'd1:    return 3'b011;
                3'd2:    return 3'b101;
                3'd3:    return 3'b111;
                default: return 3'b001;
            endcase
        end else begin
            return 3'b001;
        end
    endfunction

    assign unused_bits = ^{src_addr[1:0], dest_addr[1:0], ts[1:0]};

    assign blen       = burst_len(bs_q);
    assign nbeats     = (words_q < WC_W'(blen)) ? words_q[4:0] : blen;
    assign last_beat  = (beat_p0 == nbeats - 5'd1);
    assign hburst_cur = burst_code(bs_q, nbeats, blen);
    assign bus_err    = vld_p1 && (m_HRESP == 2'b01);
    assign accept     = start && !busy_q && (state == S_IDLE);
    // The first NONSEQ of a read burst only counts while the grant is still held.
    assign beat_go    = m_HREADY && !bus_err &&
                        ((state == S_WR) ||
                         ((state == S_RD) && (m_HGRANT || (beat_p0 != 5'd0))));

    always_ff @(posedge r_HCLK) begin
        if (!r_HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        m_HBUSREQ = 1'b0;
        m_HTRANS  = 2'b00;
        m_HADDR   = 32'h0;
        m_HWRITE  = 1'b0;
        m_HBURST  = 3'b000;
        m_HWDATA  = 32'h0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = (ts[TS_W-1:2] == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                m_HBUSREQ = !gap_q;
                if (!gap_q && m_HGRANT && m_HREADY) begin
                    state_nx = S_RD;
                end
            end
            S_RD: begin
                m_HBUSREQ = 1'b1;
                m_HTRANS  = (beat_p0 == 5'd0) ? 2'b10 : 2'b11;
                m_HADDR   = src_q + {25'd0, beat_p0, 2'b00};
                m_HBURST  = hburst_cur;
                if (bus_err) begin
                    state_nx = S_DONE;
                end else if ((beat_p0 == 5'd0) && !m_HGRANT) begin
                    state_nx = S_REQ;
                end else if (beat_go && last_beat) begin
                    state_nx = S_RD_LAST;
                end
            end
            S_RD_LAST: begin
                m_HBUSREQ = 1'b1;
                if (bus_err) begin
                    state_nx = S_DONE;
                end else if (m_HREADY) begin
                    state_nx = S_WR;
                end
            end
            S_WR: begin
                m_HBUSREQ = 1'b1;
                m_HTRANS  = (beat_p0 == 5'd0) ? 2'b10 : 2'b11;
                m_HADDR   = dst_q + {25'd0, beat_p0, 2'b00};
                m_HWRITE  = 1'b1;
                m_HBURST  = hburst_cur;
                if (vld_p1) begin
                    m_HWDATA = buf_q[beat_p1];
                end
                if (bus_err) begin
                    state_nx = S_DONE;
                end else if (beat_go && last_beat) begin
                    state_nx = S_WR_LAST;
                end
            end
            S_WR_LAST: begin
                m_HBUSREQ = 1'b1;
                m_HWRITE  = 1'b1;
                if (vld_p1) begin
                    m_HWDATA = buf_q[beat_p1];
                end
                if (bus_err) begin
                    state_nx = S_DONE;
                end else if (m_HREADY) begin
                    state_nx = (words_q == WC_W'(nbeats)) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge r_HCLK) begin
        if (!r_HRESETn) begin
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            words_q <= '0;
            bs_q    <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            gap_q   <= 1'b0;
            beat_p0 <= 5'd0;
            vld_p1  <= 1'b0;
            beat_p1 <= '0;
        end else begin
            done_q <= (state == S_DONE);
            gap_q  <= (state == S_WR_LAST) && (state_nx == S_REQ);
            if (done_q) begin
                busy_q <= 1'b0;
            end
            if (accept) begin
                src_q   <= {src_addr[31:2], 2'b00};
                dst_q   <= {dest_addr[31:2], 2'b00};
                words_q <= ts[TS_W-1:2];
                bs_q    <= bs;
                busy_q  <= 1'b1;
                error_q <= 1'b0;
            end
            // Address phase (p0) hands its beat to the data phase (p1) on every accepted HREADY.
            if (bus_err) begin
                error_q <= 1'b1;
                vld_p1  <= 1'b0;
                beat_p0 <= 5'd0;
            end else if (beat_go) begin
                vld_p1  <= 1'b1;
                beat_p1 <= beat_p0[BI_W-1:0];
                beat_p0 <= last_beat ? 5'd0 : beat_p0 + 5'd1;
            end else if (m_HREADY && ((state == S_RD_LAST) || (state == S_WR_LAST))) begin
                vld_p1 <= 1'b0;
                if (state == S_WR_LAST) begin
                    src_q   <= src_q + {25'd0, nbeats, 2'b00};
                    dst_q   <= dst_q + {25'd0, nbeats, 2'b00};
                    words_q <= words_q - WC_W'(nbeats);
                end
            end
        end
    end

    // Data phase (p1) of a read: capture the beat into its buffer slot.
    always_ff @(posedge r_HCLK) begin
        if (vld_p1 && m_HREADY && !bus_err && ((state == S_RD) || (state == S_RD_LAST))) begin
            buf_q[beat_p1] <= m_HRDATA;
        end
    end

    assign m_HSIZE = 3'b010;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_dmac_ahb_burst_master.sv
// Directed bench for dmac_ahb_burst_master with a small AHB memory slave that returns addr^0xA5A50000.
module tb_dmac_ahb_burst_master;

    logic        r_HCLK = 1'b0;
    logic        r_HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dest_addr = 32'h0;
    logic [11:0] ts = 12'h0;
    logic [2:0]  bs = 3'd0;
    logic        m_HGRANT = 1'b1;
    logic        m_HREADY = 1'b1;
    logic [1:0]  m_HRESP = 2'b00;
    logic [31:0] m_HRDATA;
    logic        m_HBUSREQ;
    logic [31:0] m_HADDR;
    logic [1:0]  m_HTRANS;
    logic        m_HWRITE;
    logic [2:0]  m_HSIZE;
    logic [2:0]  m_HBURST;
    logic [31:0] m_HWDATA;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;

    logic        dp_vld = 1'b0;
    logic        dp_wr = 1'b0;
    logic [31:0] dp_addr = 32'h0;
    logic [31:0] ap_addr [256];
    logic        ap_wr [256];
    logic [1:0]  ap_trans [256];
    logic [2:0]  ap_burst [256];
    int          ap_n = 0;
    logic [31:0] wd_addr [256];
    logic [31:0] wd_data [256];
    int          wd_n = 0;
    int          done_n = 0;

    always #5 r_HCLK = ~r_HCLK;

    dmac_ahb_burst_master #(.BUF_DEPTH(16), .TS_W(12)) dut (
        .r_HCLK(r_HCLK), .r_HRESETn(r_HRESETn), .start(start), .src_addr(src_addr),
        .dest_addr(dest_addr), .ts(ts), .bs(bs), .m_HGRANT(m_HGRANT), .m_HREADY(m_HREADY),
        .m_HRESP(m_HRESP), .m_HRDATA(m_HRDATA), .m_HBUSREQ(m_HBUSREQ), .m_HADDR(m_HADDR),
        .m_HTRANS(m_HTRANS), .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST),
        .m_HWDATA(m_HWDATA), .busy(busy), .done(done), .error(error)
    );

    assign m_HRDATA = (dp_vld && !dp_wr) ? (dp_addr ^ 32'hA5A5_0000) : 32'h0;

    always @(posedge r_HCLK) begin
        if (m_HREADY) begin
            if (dp_vld && dp_wr && wd_n < 256) begin
                wd_addr[wd_n] = dp_addr;
                wd_data[wd_n] = m_HWDATA;
                wd_n = wd_n + 1;
            end
            if (m_HTRANS[1] && ap_n < 256) begin
                ap_addr[ap_n]  = m_HADDR;
                ap_wr[ap_n]    = m_HWRITE;
                ap_trans[ap_n] = m_HTRANS;
                ap_burst[ap_n] = m_HBURST;
                ap_n = ap_n + 1;
            end
            dp_vld  <= m_HTRANS[1];
            dp_addr <= m_HADDR;
            dp_wr   <= m_HWRITE;
        end
        if (done) done_n = done_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_HCLK);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [11:0] t,
                            input logic [2:0] b);
        src_addr  = s;
        dest_addr = d;
        ts        = t;
        bs        = b;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clr", 32'(error), 32'd0);
    endtask

    task automatic chk_ap(input string tag, input int idx, input logic [31:0] addr, input logic wr,
                          input logic [1:0] trans, input logic [2:0] burst);
        if (idx >= 256) begin
            chk({tag, "_idx"}, 32'(idx), 32'd0);
        end else begin
            chk({tag, "_addr"}, ap_addr[idx], addr);
            chk({tag, "_wr"}, 32'(ap_wr[idx]), 32'(wr));
            chk({tag, "_trans"}, 32'(ap_trans[idx]), 32'(trans));
            chk({tag, "_burst"}, 32'(ap_burst[idx]), 32'(burst));
        end
    endtask

    task automatic chk_wd(input string tag, input int idx, input logic [31:0] addr);
        if (idx >= 256) begin
            chk({tag, "_idx"}, 32'(idx), 32'd0);
        end else begin
            chk({tag, "_addr"}, wd_addr[idx], addr);
            chk({tag, "_data"}, wd_data[idx], 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int a0, w0, d0, n, idx, wi;
        logic [31:0] sa;

        // Reset values
        tick();
        tick();
        chk("rst_busreq", 32'(m_HBUSREQ), 32'd0);
        chk("rst_htrans", 32'(m_HTRANS), 32'd0);
        chk("rst_haddr", m_HADDR, 32'h0);
        chk("rst_hwrite", 32'(m_HWRITE), 32'd0);
        chk("rst_hburst", 32'(m_HBURST), 32'd0);
        chk("rst_hwdata", m_HWDATA, 32'h0);
        chk("rst_hsize", 32'(m_HSIZE), 32'd2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        r_HRESETn = 1'b1;
        tick();

        // Single INCR4 read then INCR4 write
        a0 = ap_n; w0 = wd_n; d0 = done_n;
        do_start(32'h100, 32'h200, 12'd16, 3'd1);
        wait_done("t1_done", 100);
        tick();
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_done_cnt", 32'(done_n - d0), 32'd1);
        chk("t1_ap_cnt", 32'(ap_n - a0), 32'd8);
        chk("t1_wd_cnt", 32'(wd_n - w0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk_ap("t1_rd", a0 + i, 32'h100 + 32'(4 * i), 1'b0, (i == 0) ? 2'b10 : 2'b11, 3'b011);
            chk_ap("t1_wr", a0 + 4 + i, 32'h200 + 32'(4 * i), 1'b1, (i == 0) ? 2'b10 : 2'b11, 3'b011);
            if (w0 + i < 256) begin
                chk("t1_wd_addr", wd_addr[w0 + i], 32'h200 + 32'(4 * i));
                chk("t1_wd_data", wd_data[w0 + i], 32'hA5A5_0100 + 32'(4 * i));
            end
        end

        // Two INCR4 bursts plus a 2-beat INCR tail; a start in mid-transfer is ignored
        a0 = ap_n; w0 = wd_n; d0 = done_n;
        do_start(32'h100, 32'h300, 12'd40, 3'd1);
        tick();
        tick();
        src_addr = 32'hF00; dest_addr = 32'hF80; ts = 12'd4; bs = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t2_done", 300);
        tick();
        chk("t2_busy_low", 32'(busy), 32'd0);
        chk("t2_done_cnt", 32'(done_n - d0), 32'd1);
        chk("t2_final_src", dut.src_q, 32'h128);
        chk("t2_final_dst", dut.dst_q, 32'h328);
        chk("t2_ap_cnt", 32'(ap_n - a0), 32'd20);
        chk("t2_wd_cnt", 32'(wd_n - w0), 32'd10);
        idx = a0; wi = w0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < ((b < 2) ? 4 : 2); i++) begin
                chk_ap("t2_rd", idx, 32'h100 + 32'(16 * b + 4 * i), 1'b0,
                       (i == 0) ? 2'b10 : 2'b11, (b < 2) ? 3'b011 : 3'b001);
                idx++;
            end
            for (int i = 0; i < ((b < 2) ? 4 : 2); i++) begin
                chk_ap("t2_wr", idx, 32'h300 + 32'(16 * b + 4 * i), 1'b1,
                       (i == 0) ? 2'b10 : 2'b11, (b < 2) ? 3'b011 : 3'b001);
                idx++;
                if (wi < 256) begin
                    sa = 32'h100 + 32'(16 * b + 4 * i);
                    chk("t2_wd_addr", wd_addr[wi], 32'h300 + 32'(16 * b + 4 * i));
                    chk("t2_wd_data", wd_data[wi], sa ^ 32'hA5A5_0000);
                end
                wi++;
            end
        end

        // SINGLE bursts with HREADY stalls on the second word's write
        a0 = ap_n; w0 = wd_n;
        do_start(32'h400, 32'h500, 12'd16, 3'd0);
        n = 0;
        while (!(m_HTRANS == 2'b10 && m_HWRITE && m_HADDR == 32'h504) && n < 200) begin
            tick();
            n++;
        end
        chk("t3_find_wr1", m_HADDR, 32'h504);
        m_HREADY = 1'b0;
        tick();
        chk("t3_hold_addr_a", m_HADDR, 32'h504);
        chk("t3_hold_trans_a", 32'(m_HTRANS), 32'd2);
        tick();
        chk("t3_hold_addr_b", m_HADDR, 32'h504);
        m_HREADY = 1'b1;
        tick();
        chk("t3_wdata", m_HWDATA, 32'hA5A5_0404);
        m_HREADY = 1'b0;
        tick();
        chk("t3_hold_wdata_a", m_HWDATA, 32'hA5A5_0404);
        chk("t3_idle_trans", 32'(m_HTRANS), 32'd0);
        tick();
        chk("t3_hold_wdata_b", m_HWDATA, 32'hA5A5_0404);
        m_HREADY = 1'b1;
        wait_done("t3_done", 200);
        tick();
        chk("t3_ap_cnt", 32'(ap_n - a0), 32'd8);
        chk("t3_wd_cnt", 32'(wd_n - w0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk_ap("t3_rd", a0 + 2 * i, 32'h400 + 32'(4 * i), 1'b0, 2'b10, 3'b000);
            chk_ap("t3_wr", a0 + 2 * i + 1, 32'h500 + 32'(4 * i), 1'b1, 2'b10, 3'b000);
            if (w0 + i < 256) begin
                chk("t3_wd_data", wd_data[w0 + i], 32'hA5A5_0400 + 32'(4 * i));
            end
        end

        // Zero-length transfer; start held through DONE and the done pulse is ignored
        a0 = ap_n; d0 = done_n;
        src_addr = 32'h40; dest_addr = 32'h80; ts = 12'd0; bs = 3'd1;
        start = 1'b1;
        tick();
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_done_early", 32'(done), 32'd0);
        chk("t4_busreq_a", 32'(m_HBUSREQ), 32'd0);
        ts = 12'd16;
        tick();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busreq_b", 32'(m_HBUSREQ), 32'd0);
        chk("t4_trans_b", 32'(m_HTRANS), 32'd0);
        tick();
        start = 1'b0;
        chk("t4_done_off", 32'(done), 32'd0);
        chk("t4_busy_off", 32'(busy), 32'd0);
        tick();
        chk("t4_still_idle", 32'(busy), 32'd0);
        chk("t4_busreq_c", 32'(m_HBUSREQ), 32'd0);
        chk("t4_no_xfer", 32'(ap_n - a0), 32'd0);
        chk("t4_done_cnt", 32'(done_n - d0), 32'd1);

        // ERROR response on read beat 2 of an INCR4
        a0 = ap_n; w0 = wd_n;
        do_start(32'h600, 32'h700, 12'd16, 3'd1);
        n = 0;
        while (!(m_HTRANS == 2'b11 && m_HADDR == 32'h60C) && n < 100) begin
            tick();
            n++;
        end
        chk("t5_find_rd3", m_HADDR, 32'h60C);
        m_HRESP = 2'b01;
        m_HREADY = 1'b0;
        tick();
        chk("t5_trans_idle", 32'(m_HTRANS), 32'd0);
        chk("t5_busreq_off", 32'(m_HBUSREQ), 32'd0);
        chk("t5_error", 32'(error), 32'd1);
        m_HRESP = 2'b00;
        m_HREADY = 1'b1;
        tick();
        chk("t5_done", 32'(done), 32'd1);
        tick();
        chk("t5_busy_off", 32'(busy), 32'd0);
        chk("t5_error_sticky", 32'(error), 32'd1);
        chk("t5_rd_cnt", 32'(ap_n - a0), 32'd3);
        chk("t5_no_write", 32'(wd_n - w0), 32'd0);

        // Reset in the middle of a write burst, then a fresh 2-beat transfer
        do_start(32'h800, 32'h900, 12'd16, 3'd1);
        n = 0;
        while (!(m_HWRITE && m_HTRANS == 2'b11) && n < 100) begin
            tick();
            n++;
        end
        chk("t6_find_wr1", m_HADDR, 32'h904);
        r_HRESETn = 1'b0;
        tick();
        chk("t6_busreq", 32'(m_HBUSREQ), 32'd0);
        chk("t6_htrans", 32'(m_HTRANS), 32'd0);
        chk("t6_haddr", m_HADDR, 32'h0);
        chk("t6_hwrite", 32'(m_HWRITE), 32'd0);
        chk("t6_hburst", 32'(m_HBURST), 32'd0);
        chk("t6_hwdata", m_HWDATA, 32'h0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_error", 32'(error), 32'd0);
        r_HRESETn = 1'b1;
        tick();
        tick();
        a0 = ap_n; w0 = wd_n; d0 = done_n;
        do_start(32'hA00, 32'hB00, 12'd8, 3'd1);
        wait_done("t6_done_fresh", 100);
        tick();
        chk("t6_busy_low", 32'(busy), 32'd0);
        chk("t6_done_cnt", 32'(done_n - d0), 32'd1);
        chk("t6_ap_cnt", 32'(ap_n - a0), 32'd4);
        chk_ap("t6_rd0", a0, 32'hA00, 1'b0, 2'b10, 3'b001);
        chk_ap("t6_rd1", a0 + 1, 32'hA04, 1'b0, 2'b11, 3'b001);
        chk_ap("t6_wr0", a0 + 2, 32'hB00, 1'b1, 2'b10, 3'b001);
        chk_ap("t6_wr1", a0 + 3, 32'hB04, 1'b1, 2'b11, 3'b001);
        chk("t6_wd_cnt", 32'(wd_n - w0), 32'd2);
        for (int i = 0; i < 2; i++) begin
            if (w0 + i < 256) begin
                chk("t6_wd_addr", wd_addr[w0 + i], 32'hB00 + 32'(4 * i));
                chk("t6_wd_data", wd_data[w0 + i], 32'hA5A5_0A00 + 32'(4 * i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
